// File: rtl/counter8_seq_if.sv
`default_nettype none
// ============================================================================
// Module : counter8_seq_if
// Brief  : Command handshake bundle ({preset, terminal} over valid/ready).
// Rev    : 1.0
// ============================================================================
interface counter8_seq_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_end;

    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_end,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_end,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/counter8_seq.sv
`default_nettype none
// ============================================================================
// Module : counter8_seq
// Brief  : Sequencer that loads, runs and stops a loadable up-counter.
// Rev    : 1.0
// ============================================================================
module counter8_seq #(
    parameter int WIDTH       = 8,
    parameter int LOAD_CYCLES = 1
) (
    input  wire logic             clk,
    input  wire logic             clr,
    counter8_seq_if.slave         cmd,
    input  wire logic             pause,
    input  wire logic             abort,
    input  wire logic [WIDTH-1:0] cnt_in,
    output logic                  cnt_load,
    output logic                  cnt_run,
    output logic [WIDTH-1:0]      cnt_data,
    output logic                  busy,
    output logic                  done
);

    localparam int c_LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [c_LOAD_W-1:0] c_LOAD_LAST = c_LOAD_W'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_end;
    logic [WIDTH-1:0]    r_data;
    logic [c_LOAD_W-1:0] r_load_cnt;
    logic                r_done;
    logic                w_at_end;

    assign w_at_end = (cnt_in == r_end);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_end      <= '0;
            r_data     <= '0;
            r_load_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (cmd.cmd_valid && !abort) begin
                        r_end      <= cmd.cmd_end;
                        r_data     <= cmd.cmd_start;
                        r_load_cnt <= '0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        r_load_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else if (r_load_cnt == c_LOAD_LAST) begin
                        r_load_cnt <= '0;
                        r_state    <= S_RUN;
                    end else begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // Completion is checked ahead of pause so a paused run at its terminal still finishes.
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_at_end) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign cnt_load      = (r_state == S_LOAD) && !abort;
    assign cnt_run       = (r_state == S_RUN) && !abort && !pause && !w_at_end;
    assign cnt_data      = r_data;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_counter8_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_counter8_seq
// Brief  : Directed bench with a behavioural sequencer model and counter.
// Rev    : 1.0
// ============================================================================
module tb_counter8_seq;

    localparam int W = 8;
    localparam int L = 1;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] cnt = '0;
    logic         cnt_load, cnt_run, busy, done;
    logic [W-1:0] cnt_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    counter8_seq_if #(.WIDTH(W)) cmd_if ();

    counter8_seq #(.WIDTH(W), .LOAD_CYCLES(L)) dut (
        .clk      (clk),
        .clr      (clr),
        .cmd      (cmd_if.slave),
        .pause    (pause),
        .abort    (abort),
        .cnt_in   (cnt),
        .cnt_load (cnt_load),
        .cnt_run  (cnt_run),
        .cnt_data (cnt_data),
        .busy     (busy),
        .done     (done)
    );

    // The controlled counter: load wins, otherwise increment when running.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_load)     cnt <= cnt_data;
        else if (cnt_run) cnt <= cnt + 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a command occupies L load cycles, then needs
    // (end-start) mod 2^W counting steps, then one done cycle.
    bit           m_active, m_done_now;
    int           m_load_left, m_steps;
    logic [W-1:0] m_data, m_end;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_active <= 0; m_done_now <= 0; m_load_left <= 0; m_steps <= 0;
            m_data <= '0; m_end <= '0;
        end else if (!m_active) begin
            if (cmd_if.cmd_valid && !abort) begin
                m_active    <= 1;
                m_load_left <= L;
                m_steps     <= (int'(cmd_if.cmd_end) - int'(cmd_if.cmd_start) + (1 << W)) % (1 << W);
                m_data      <= cmd_if.cmd_start;
                m_end       <= cmd_if.cmd_end;
            end
        end else if (abort || m_done_now) begin
            m_active <= 0; m_done_now <= 0;
        end else if (m_load_left > 0) begin
            m_load_left <= m_load_left - 1;
        end else if (m_steps == 0) begin
            m_done_now <= 1;
        end else if (!pause) begin
            m_steps <= m_steps - 1;
        end
    end

    int hs_cnt = 0, done_cnt = 0, last_hs = 0, last_done = 0, last_load = 0, run_cycles = 0;

    always @(negedge clk) begin
        check("ready", cmd_if.cmd_ready, !m_active);
        check("busy", busy, m_active);
        check("load", cnt_load, m_active && m_load_left > 0 && !abort);
        check("run", cnt_run, m_active && m_load_left == 0 && !m_done_now && m_steps > 0 && !pause && !abort);
        check("done", done, m_done_now);
        check("data", cnt_data, m_data);
        if (m_done_now) check("cnt_at_done", cnt, m_end);
        if (clr && cmd_if.cmd_valid && cmd_if.cmd_ready && !abort) begin
            hs_cnt <= hs_cnt + 1; last_hs <= cyc; run_cycles <= 0;
        end else if (cnt_run) begin
            run_cycles <= run_cycles + 1;
        end
        if (done)     begin done_cnt <= done_cnt + 1; last_done <= cyc; end
        if (cnt_load) last_load <= cyc;
    end

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] e);
        int h0;
        h0 = hs_cnt;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_start = s; cmd_if.cmd_end = e;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        check("accepted", hs_cnt, h0 + 1);
    endtask

    task automatic wait_done(input int budget);
        int  n0;
        bit  ok;
        n0 = done_cnt;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (done_cnt != n0) ok = 1;
        end
        #1;
        check("done_seen", ok, 1);
    endtask

    initial begin
        int  t, d0, h0;
        bit  found;
        logic [W-1:0] cnt_save;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_start = '0; cmd_if.cmd_end = '0;

        // Reset state
        @(negedge clk);
        check("rst_ready", cmd_if.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_load", cnt_load, 0);
        check("rst_run", cnt_run, 0);
        check("rst_data", cnt_data, 0);
        @(posedge clk); #1 clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Wrapping run F0 -> 05: 21 steps, done at T+L+21+2
        send(8'hF0, 8'h05);
        t = last_hs;
        wait_done(60);
        check("wrap_load_cyc", last_load, t + 1);
        check("wrap_done_cyc", last_done, t + 24);
        check("wrap_run_cycles", run_cycles, 21);
        repeat (3) @(posedge clk);
        #1;
        check("wrap_hold", cnt, 8'h05);
        check("wrap_idle", cmd_if.cmd_ready, 1);

        // Pause for 3 RUN cycles: 10 -> 14 finishes 3 cycles later
        send(8'h10, 8'h14);
        t = last_hs;
        repeat (2) @(posedge clk);
        #1 pause = 1'b1;
        repeat (3) @(posedge clk);
        #1 pause = 1'b0;
        wait_done(30);
        check("pause_done_cyc", last_done, t + 10);
        check("pause_run_cycles", run_cycles, 4);
        check("pause_cnt", cnt, 8'h14);
        @(posedge clk); #1;

        // Zero-length command
        send(8'h3C, 8'h3C);
        t = last_hs;
        wait_done(20);
        check("zero_done_cyc", last_done, t + 3);
        check("zero_run_cycles", run_cycles, 0);
        @(posedge clk); #1;

        // Abort mid-run at count 20
        send(8'h10, 8'h40);
        d0 = done_cnt;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (cnt == 8'h20) found = 1;
        end
        check("abort_reach20", found, 1);
        abort = 1'b1;
        @(negedge clk);
        check("abort_run_off", cnt_run, 0);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_idle", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, d0);
        check("abort_cnt_held", cnt, 8'h20);

        // Busy rejection: valid held with new values through the run
        h0 = hs_cnt;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_start = 8'h01; cmd_if.cmd_end = 8'h05;
        @(posedge clk); #1;
        cmd_if.cmd_start = 8'hAA; cmd_if.cmd_end = 8'hBB;
        wait_done(30);
        check("busy_single_hs", hs_cnt, h0 + 1);
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        check("busy_second_hs", hs_cnt, h0 + 2);
        check("busy_hs_after_done", last_hs, last_done + 1);
        repeat (4) @(posedge clk);
        #1;
        check("busy_data", cnt_data, 8'hAA);
        check("busy_running", cnt_run, 1);

        // Asynchronous clear mid-run
        cnt_save = cnt;
        clr = 1'b0;
        @(negedge clk);
        check("clr_ready", cmd_if.cmd_ready, 1);
        check("clr_busy", busy, 0);
        check("clr_run", cnt_run, 0);
        check("clr_load", cnt_load, 0);
        check("clr_data", cnt_data, 0);
        @(posedge clk); #1 clr = 1'b1;
        check("clr_cnt_untouched", cnt, cnt_save);
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
